detect_event_fifo: RTL and testbench
====================================

# detect_event_fifo

Downstream consumer of the serial pattern detector's `detected` pulse. Each cycle on which `detected` is high, the block stamps the event with a free-running cycle timestamp and queues it in a small FIFO. A downstream reader drains the FIFO over a valid/ready handshake. Running event count and a sticky overflow flag are kept for software-visible status.

## Interface
- `TS_W`, 16, timestamp width; the timestamp counter wraps modulo 2^TS_W.
- `DEPTH`, 4, FIFO entries; must be a power of two and at least 2.
- `CNT_W`, 8, width of the saturating event counter.

- `clk`  in  1  single clock; all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `detected`  in  1  event strobe from the detector; sampled at the `clk` rising edge. Each high cycle is one event.
- `clear`  in  1  synchronous clear of FIFO, counters and flags.
- `ev_valid`  out  1  FIFO head holds an event.
- `ev_ts`  out  TS_W  timestamp of the head event; meaningful only while `ev_valid`=1.
- `ev_ready`  in  1  reader accepts the head event.
- `ev_count`  out  CNT_W  total events seen since reset/clear, saturating at all-ones.
- `overflow`  out  1  sticky; set when an event is dropped because the FIFO is full.
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.

## Operation
- **Timestamp counter `ts`:**
  - Increments by 1 every cycle and wraps from 2^TS_W-1 to 0.
  - Forced to 0 by `clear`.
- **Push:**
  - Occurs when `detected`=1, `clear`=0, and the FIFO has room.
  - Written data is the current `ts` value, i.e. the value before this edge's increment.
- **Pop:**
  - Occurs when `ev_valid`=1, `ev_ready`=1 and `clear`=0.
  - `ev_ready` while `ev_valid`=0 has no effect.
- **Full, with simultaneous pop:** a push in the same cycle is accepted. The level is unchanged and nothing is dropped.
- **Full, no pop:** the event is dropped, `overflow` is set to 1, and the FIFO is unchanged.
- **Empty:** push and pop never coincide on an empty FIFO, because `ev_valid`=0. A push to an empty FIFO becomes visible on the next cycle.
- **`ev_count`:**
  - Increments on every `detected`=1 cycle, including dropped events.
  - Holds at 2^CNT_W-1 once reached.
- **`clear`:**
  - Empties the FIFO (level 0) and zeroes `ev_count`, `overflow` and `ts`.
  - Has priority over `detected` and `ev_ready` in the same cycle: that event is neither queued nor counted.
- **Ordering:** strictly first-in, first-out. Pointers wrap modulo DEPTH.
- **Not a handshake producer:** `detected` arrives without backpressure; loss is reported only through `overflow`.

## Timing
- **Reset values (asynchronous, while `reset_n`=0):** `ev_valid`=0, `ev_ts`=0, `ev_count`=0, `overflow`=0, `level`=0, internal `ts`=0. Reset may assert mid-burst; all state is discarded.
- **Event latency:** `detected` high at edge N gives `ev_valid`=1 and `ev_ts`=ts(N) visible after edge N, with zero added wait cycles.
- **Read side:** first-word-fall-through. `ev_ts` is the registered head entry, and the next entry appears the cycle after a pop.
- **Throughput:** one push and one pop per cycle, sustained.
- **Status outputs:** `level`, `ev_count` and `overflow` are registered and reflect the edge's push, pop and clear in the following cycle.
- **Sampling constraint:** `detected` may be a Mealy combinational output of the upstream FSM and must be stable at the edge. The block adds no input register, so no event is skipped.

## Structure
- **Package `detect_pkg`:** holds the default `TS_W`, `DEPTH` and `CNT_W` constants and a `det_event_t` struct carrying the `ts` field.
- **Sub-module `sync_fifo`:** a generic synchronous FWFT FIFO (width and depth parameters, push, pop, full, empty, level, clear).
- **Top level:** owns the timestamp counter, saturating counter, overflow flag and the push-gating logic.

## Test plan
- **Single event:** reset, release, hold `ev_ready`=0, pulse `detected` at ts=5.
  - Next cycle: `ev_valid`=1, `ev_ts`=5, `level`=1, `ev_count`=1.
  - Then assert `ev_ready` for one cycle: `ev_valid`=0, `level`=0.
- **Overflow:** DEPTH=4, `ev_ready`=0, pulse `detected` on 6 cycles at ts=10..15.
  - `level`=4, `overflow`=1, `ev_count`=6.
  - Draining returns 10, 11, 12, 13 in order.
- **Push while full with pop:** fill 4 entries, then on one cycle `detected`=1 and `ev_ready`=1.
  - `level` stays 4 and `overflow` stays 0.
  - The last entry equals the ts of that cycle.
- **Counter saturation and wrap:** CNT_W=4, TS_W=4, `detected` held high 20 cycles with `ev_ready`=1.
  - `ev_count`=15.
  - Timestamps read back 0..15 then 0..3; no overflow.
- **Clear priority:** 3 events queued, then `clear`=1 together with `detected`=1.
  - Next cycle: `level`=0, `ev_valid`=0, `ev_count`=0, `overflow`=0, ts restarts at 0.
- **Reset mid-operation:** with 2 entries queued and `overflow`=1, pulse `reset_n` low asynchronously between edges.
  - All outputs are 0 immediately.
  - The first event after release is stamped from ts=0.

Source files
------------

// File: rtl/detect_event_fifo_pkg.sv
// Shared defaults and event record for the detected-event queue.
package detect_pkg;

    localparam int DEF_TS_W  = 16;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_CNT_W = 8;

    // One queued event at the default timestamp width.
    typedef struct packed {
        logic [DEF_TS_W-1:0] ts;
    } det_event_t;

endpackage

// File: rtl/detect_event_fifo_if.sv
// Read-side valid/ready channel carrying the head event timestamp.
interface detect_event_fifo_if
    import detect_pkg::*;
#(
    parameter int TS_W = DEF_TS_W
);
    logic            ev_valid;
    logic [TS_W-1:0] ev_ts;
    logic            ev_ready;

    modport master (output ev_valid, output ev_ts, input ev_ready);
    modport slave  (input ev_valid, input ev_ts, output ev_ready);
endinterface

// File: rtl/detect_event_fifo_sync_fifo.sv
// Generic synchronous first-word-fall-through FIFO. The head entry is read
// straight out of the storage registers, so a write is visible one cycle later.
module sync_fifo
    import detect_pkg::*;
#(
    parameter int W     = DEF_TS_W,
    parameter int DEPTH = DEF_DEPTH,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     dout,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] cnt;

    // Storage: reset to zero so the head reads 0 out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (!clear && push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^PTR_W.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      cnt <= cnt + 1'b1;
            else if (pop && !push) cnt <= cnt - 1'b1;
        end
    end

    assign dout  = mem[rd_ptr];
    assign level = cnt;
    assign empty = (cnt == '0);
    assign full  = (cnt == LVL_W'(DEPTH));
endmodule

// File: rtl/detect_event_fifo.sv
// Timestamps each detector strobe and queues it for a downstream reader.
// Keeps a saturating event count and a sticky overflow flag for status.
module detect_event_fifo
    import detect_pkg::*;
#(
    parameter int TS_W  = DEF_TS_W,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       detected,
    input  logic                       clear,
    detect_event_fifo_if.master        ev,
    output logic [CNT_W-1:0]           ev_count,
    output logic                       overflow,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [TS_W-1:0] ts;
    } ev_rec_t;

    logic [TS_W-1:0] ts;
    ev_rec_t         wr_rec;
    ev_rec_t         head_rec;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic            drop;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    always_comb begin
        pop       = ev.ev_ready && !fifo_empty && !clear;
        push      = detected && !clear && (!fifo_full || pop);
        drop      = detected && !clear && fifo_full && !pop;
        wr_rec.ts = ts;
    end

    // Free-running timestamp; the pushed value is the pre-increment count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)   ts <= '0;
        else if (clear) ts <= '0;
        else            ts <= ts + 1'b1;
    end

    // Event counter counts every strobe, dropped ones included, and saturates.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                         ev_count <= '0;
        else if (clear)                       ev_count <= '0;
        else if (detected && ev_count != '1)  ev_count <= ev_count + 1'b1;
    end

    // Sticky loss indicator, only cleared by reset or clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)   overflow <= 1'b0;
        else if (clear) overflow <= 1'b0;
        else if (drop)  overflow <= 1'b1;
    end

    sync_fifo #(
        .W     ($bits(ev_rec_t)),
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .push    (push),
        .pop     (pop),
        .din     (wr_rec),
        .dout    (head_rec),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    assign ev.ev_valid = !fifo_empty;
    assign ev.ev_ts    = head_rec.ts;
endmodule

// File: tb/tb_detect_event_fifo.sv
// Randomized and directed checks of detect_event_fifo against a queue model.
module tb_detect_event_fifo;
    localparam int TS_W  = 4;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int TS_MOD  = 1 << TS_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic detected = 1'b0;
    logic clear = 1'b0;
    logic [CNT_W-1:0] ev_count;
    logic overflow;
    logic [$clog2(DEPTH):0] level;

    detect_event_fifo_if #(.TS_W(TS_W)) ev_if();

    detect_event_fifo #(.TS_W(TS_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .detected (detected),
        .clear    (clear),
        .ev       (ev_if),
        .ev_count (ev_count),
        .overflow (overflow),
        .level    (level)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    // Reference model: a plain queue of timestamps plus scalar status.
    int q[$];
    int mts;
    int mcnt;
    int movf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        mts = 0; mcnt = 0; movf = 0;
    endtask

    task automatic check_model();
        chk("valid", 32'(ev_if.ev_valid), 32'(q.size() != 0));
        if (q.size() != 0) chk("head_ts", 32'(ev_if.ev_ts), 32'(q[0]));
        chk("level", 32'(level), 32'(q.size()));
        chk("count", 32'(ev_count), 32'(mcnt));
        chk("overflow", 32'(overflow), 32'(movf));
    endtask

    // Drive one cycle of inputs, advance the model at the edge, check after it.
    task automatic step(input bit det, input bit rdy, input bit clr);
        bit pop;
        detected = det;
        ev_if.ev_ready = rdy;
        clear = clr;
        pop = (q.size() != 0) && rdy && !clr;
        @(posedge clk);
        if (clr) begin
            model_reset();
        end else begin
            bit was_full;
            was_full = (q.size() == DEPTH);
            if (pop) void'(q.pop_front());
            if (det) begin
                if (mcnt < CNT_MAX) mcnt++;
                if (!was_full || pop) q.push_back(mts);
                else movf = 1;
            end
            mts = (mts + 1) % TS_MOD;
        end
        #1;
        check_model();
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset();
        reset_n = 1'b0;
        detected = 1'b0;
        clear = 1'b0;
        ev_if.ev_ready = 1'b0;
        #2;
        chk("rst_valid", 32'(ev_if.ev_valid), 0);
        chk("rst_ts", 32'(ev_if.ev_ts), 0);
        chk("rst_count", 32'(ev_count), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_level", 32'(level), 0);
        model_reset();
        reset_n = 1'b1;
        #1;
    endtask

    initial begin
        ev_if.ev_ready = 1'b0;
        #1;
        do_reset();

        // Single event at ts=5
        while (mts != 5) step(0, 0, 0);
        step(1, 0, 0);
        chk("single_valid", 32'(ev_if.ev_valid), 1);
        chk("single_ts", 32'(ev_if.ev_ts), 5);
        chk("single_level", 32'(level), 1);
        chk("single_count", 32'(ev_count), 1);
        step(0, 1, 0);
        chk("single_pop_valid", 32'(ev_if.ev_valid), 0);
        chk("single_pop_level", 32'(level), 0);

        // Overflow: six strobes at ts=10..15 into four slots
        do_reset();
        while (mts != 10) step(0, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 0, 0);
        chk("ovf_level", 32'(level), 4);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_count", 32'(ev_count), 6);
        for (int i = 0; i < 4; i++) begin
            chk("ovf_drain", 32'(ev_if.ev_ts), 32'(10 + i));
            step(0, 1, 0);
        end

        // Push while full with simultaneous pop
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 0, 0);
        step(1, 1, 0);
        chk("fullpop_level", 32'(level), 4);
        chk("fullpop_ovf", 32'(overflow), 0);
        for (int i = 0; i < 4; i++) begin
            chk("fullpop_drain", 32'(ev_if.ev_ts), 32'(1 + i));
            step(0, 1, 0);
        end

        // Count saturation and timestamp wrap with continuous draining
        do_reset();
        for (int k = 0; k < 20; k++) begin
            step(1, 1, 0);
            chk("wrap_ts", 32'(ev_if.ev_ts), 32'(k % TS_MOD));
        end
        chk("sat_count", 32'(ev_count), 15);
        chk("sat_ovf", 32'(overflow), 0);

        // Clear wins over a coincident strobe
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 0, 0);
        step(1, 0, 1);
        chk("clr_level", 32'(level), 0);
        chk("clr_valid", 32'(ev_if.ev_valid), 0);
        chk("clr_count", 32'(ev_count), 0);
        step(1, 0, 0);
        chk("clr_ts_restart", 32'(ev_if.ev_ts), 0);

        // Reset mid-operation with two entries and overflow set
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 0, 0);
        step(0, 1, 0);
        step(0, 1, 0);
        chk("pre_rst_level", 32'(level), 2);
        chk("pre_rst_ovf", 32'(overflow), 1);
        do_reset();
        step(1, 0, 0);
        chk("post_rst_ts", 32'(ev_if.ev_ts), 0);

        // Randomized traffic with varying reader pressure
        for (int n = 0; n < 600; n++) begin
            int rdy_pct;
            rdy_pct = ((n / 100) % 2 == 0) ? 30 : 80;
            if ($urandom_range(199) == 0) do_reset();
            step($urandom_range(99) < 60, $urandom_range(99) < rdy_pct,
                 $urandom_range(59) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
